// File: rtl/spike_train_decoder_pkg.sv
// Shared types and constants for the spike train decoder.
package spike_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } det_state_t;

  localparam logic signed [7:0] THRESH_DEFAULT = 8'sd16;
  localparam logic signed [7:0] HYST_DEFAULT   = 8'sd32;
  localparam int                RATE_W         = 8;

  // Saturating increment used by the spike counter.
  function automatic logic [RATE_W-1:0] sat_inc(input logic [RATE_W-1:0] v, input logic en);
    if (en && (v != {RATE_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/spike_train_decoder_if.sv
// Rate result valid/ready channel between the decoder and its consumer.
interface spike_train_decoder_if;

  logic [spike_pkg::RATE_W-1:0] rate_o;
  logic                         rate_valid_o;
  logic                         rate_ready_i;

  modport master (output rate_o, output rate_valid_o, input rate_ready_i);
  modport slave  (input rate_o, input rate_valid_o, output rate_ready_i);

endinterface

// File: rtl/spike_train_decoder_detector.sv
// Threshold crossing detector with hysteresis re-arm and a registered spike pulse.
module spike_detector
  import spike_pkg::*;
#(
  parameter logic signed [7:0] HYST = HYST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic signed [7:0] v_in,
  input  logic signed [7:0] thresh,
  output logic              fire,
  output logic              spike_o
);

  det_state_t        state_reg, state_next;
  logic              spike_reg;
  logic signed [8:0] v_ext;
  logic signed [8:0] rearm_level;

  // Re-arm level is formed one bit wider so thresh - HYST cannot wrap.
  assign v_ext       = {v_in[7], v_in};
  assign rearm_level = {thresh[7], thresh} - {HYST[7], HYST};

  always_comb begin
    state_next = state_reg;
    fire       = 1'b0;
    if (ena) begin
      case (state_reg)
        ARMED: begin
          if (v_in > thresh) begin
            state_next = FIRED;
            fire       = 1'b1;
          end
        end
        FIRED: begin
          if (v_ext < rearm_level) begin
            state_next = ARMED;
          end
        end
        default: state_next = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ARMED;
      spike_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      spike_reg <= fire;
    end
  end

  assign spike_o = spike_reg;

endmodule

// File: rtl/spike_train_decoder.sv
// Spike rate / inter-spike-interval decoder for a neuron voltage stream.
// Define SPIKE_TRAIN_DECODER_ISI_EN to build the inter-spike-interval measurement.
module spike_train_decoder
  import spike_pkg::*;
#(
  parameter int                WIN_LOG2 = 10,
  parameter int                ISI_W    = 16,
  parameter logic signed [7:0] HYST     = HYST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic signed [7:0]     v_in,
  input  logic signed [7:0]     thresh,
  spike_train_decoder_if.master rate_bus,
  output logic                  spike_o,
  output logic                  overrun_o,
  output logic [ISI_W-1:0]      isi_o
);

  logic                fire;
  logic [WIN_LOG2-1:0] win_cnt_reg;
  logic [RATE_W-1:0]   spike_cnt_reg;
  logic [RATE_W-1:0]   spike_cnt_next;
  logic [RATE_W-1:0]   rate_reg;
  logic                rate_valid_reg;
  logic                overrun_reg;
  logic                wrap;
  logic                accept;

  spike_detector #(
    .HYST (HYST)
  ) u_detector (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .v_in    (v_in),
    .thresh  (thresh),
    .fire    (fire),
    .spike_o (spike_o)
  );

  // A spike detected on the terminal cycle is folded into that window's result.
  assign spike_cnt_next = sat_inc(spike_cnt_reg, fire);
  assign wrap           = ena && (win_cnt_reg == {WIN_LOG2{1'b1}});
  assign accept         = rate_valid_reg && rate_bus.rate_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt_reg    <= '0;
      spike_cnt_reg  <= '0;
      rate_reg       <= '0;
      rate_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (ena) begin
        win_cnt_reg <= win_cnt_reg + 1'b1;
      end
      spike_cnt_reg <= wrap ? '0 : spike_cnt_next;
      if (wrap) begin
        rate_reg       <= spike_cnt_next;
        rate_valid_reg <= 1'b1;
        if (rate_valid_reg && !rate_bus.rate_ready_i) begin
          overrun_reg <= 1'b1;
        end
      end else if (accept) begin
        rate_valid_reg <= 1'b0;
      end
    end
  end

  assign rate_bus.rate_o       = rate_reg;
  assign rate_bus.rate_valid_o = rate_valid_reg;
  assign overrun_o             = overrun_reg;

`ifdef SPIKE_TRAIN_DECODER_ISI_EN
  logic [ISI_W-1:0] isi_cnt_reg;
  logic [ISI_W-1:0] isi_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isi_cnt_reg <= '0;
      isi_reg     <= '0;
    end else if (ena) begin
      if (fire) begin
        isi_reg     <= isi_cnt_reg;
        isi_cnt_reg <= ISI_W'(1);
      end else if (isi_cnt_reg != {ISI_W{1'b1}}) begin
        isi_cnt_reg <= isi_cnt_reg + 1'b1;
      end
    end
  end

  assign isi_o = isi_reg;
`else
  assign isi_o = '0;
`endif

endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed bench for spike_train_decoder with a 16-cycle rate window.
module tb_spike_train_decoder;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic signed [7:0] v_in;
  logic signed [7:0] thresh;
  logic              spike_o;
  logic              overrun_o;
  logic [15:0]       isi_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SPIKE_TRAIN_DECODER_ISI_EN
  localparam int ISI_EXP = 10;
`else
  localparam int ISI_EXP = 0;
`endif

  spike_train_decoder_if rate_bus ();

  spike_train_decoder #(
    .WIN_LOG2 (4),
    .ISI_W    (16),
    .HYST     (8'sd32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .v_in      (v_in),
    .thresh    (thresh),
    .rate_bus  (rate_bus),
    .spike_o   (spike_o),
    .overrun_o (overrun_o),
    .isi_o     (isi_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [7:0] v);
    v_in = v;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena   = 1'b0;
    v_in  = 8'sd0;
    rate_bus.rate_ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ena   = 1'b1;
  endtask

  function automatic logic signed [7:0] alt4(input int c);
    return (((c / 4) % 2) == 0) ? 8'sd40 : -8'sd32;
  endfunction

  function automatic logic signed [7:0] pulse5(input int c);
    return ((c % 5) == 0) ? 8'sd40 : -8'sd32;
  endfunction

  function automatic logic signed [7:0] pulse10(input int c);
    return ((c % 10) == 0) ? 8'sd40 : -8'sd32;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int quiet_spikes;
    int gap_spikes;
    thresh = 8'sd16;

    // Reset state, checked while reset is held.
    rst_n = 1'b0;
    ena   = 1'b1;
    v_in  = 8'sd40;
    rate_bus.rate_ready_i = 1'b0;
    tick();
    tick();
    check_val("rst_spike", spike_o, 0);
    check_val("rst_rate", rate_bus.rate_o, 0);
    check_val("rst_valid", rate_bus.rate_valid_o, 0);
    check_val("rst_overrun", overrun_o, 0);
    check_val("rst_isi", isi_o, 0);

    // Constant supra-threshold input: exactly one spike.
    do_reset();
    drive(8'sd40);
    check_val("hold_first_spike", spike_o, 1);
    drive(8'sd40);
    check_val("hold_pulse_end", spike_o, 0);
    quiet_spikes = 0;
    for (int c = 2; c < 15; c++) begin
      drive(8'sd40);
      if (spike_o) quiet_spikes++;
    end
    check_val("hold_no_more_spikes", quiet_spikes, 0);
    check_val("hold_valid_c15", rate_bus.rate_valid_o, 0);
    drive(8'sd40);
    check_val("hold_valid_c16", rate_bus.rate_valid_o, 1);
    check_val("hold_rate", rate_bus.rate_o, 1);

    // Alternating pattern, then accept coinciding with the next wrap.
    do_reset();
    for (int c = 0; c < 15; c++) drive(alt4(c));
    check_val("alt_valid_c15", rate_bus.rate_valid_o, 0);
    drive(alt4(15));
    check_val("alt_valid_c16", rate_bus.rate_valid_o, 1);
    check_val("alt_rate", rate_bus.rate_o, 2);
    for (int wc = 0; wc < 15; wc++) begin
      drive(pulse5(wc));
      if (wc == 7) begin
        check_val("alt_rate_stable", rate_bus.rate_o, 2);
        check_val("alt_valid_stable", rate_bus.rate_valid_o, 1);
      end
    end
    rate_bus.rate_ready_i = 1'b1;
    drive(pulse5(15));
    check_val("acc_wrap_valid", rate_bus.rate_valid_o, 1);
    check_val("acc_wrap_rate", rate_bus.rate_o, 4);
    check_val("acc_wrap_overrun", overrun_o, 0);
    check_val("terminal_spike", spike_o, 1);
    ena = 1'b0;
    tick();
    check_val("accept_ena_low", rate_bus.rate_valid_o, 0);
    rate_bus.rate_ready_i = 1'b0;

    // Two unaccepted windows: overrun.
    do_reset();
    for (int c = 0; c < 16; c++) drive(pulse5(c));
    check_val("ovr_first_rate", rate_bus.rate_o, 4);
    check_val("ovr_first_overrun", overrun_o, 0);
    for (int c = 0; c < 16; c++) drive(alt4(c));
    check_val("ovr_second_rate", rate_bus.rate_o, 1);
    check_val("ovr_valid", rate_bus.rate_valid_o, 1);
    check_val("ovr_overrun", overrun_o, 1);

    // Spikes every 10 cycles: interval.
    do_reset();
    for (int i = 0; i < 21; i++) drive(pulse10(i));
    check_val("isi_spike", spike_o, 1);
    check_val("isi_value", isi_o, ISI_EXP);

    // Enable low for 50 cycles mid-window.
    do_reset();
    for (int e = 0; e < 8; e++) drive(pulse10(e));
    ena  = 1'b0;
    gap_spikes = 0;
    for (int g = 0; g < 50; g++) begin
      drive(8'sd40);
      if (spike_o) gap_spikes++;
    end
    check_val("gap_spikes", gap_spikes, 0);
    check_val("gap_valid", rate_bus.rate_valid_o, 0);
    ena = 1'b1;
    for (int e = 8; e < 15; e++) drive(pulse10(e));
    check_val("gap_valid_e15", rate_bus.rate_valid_o, 0);
    check_val("gap_isi", isi_o, ISI_EXP);
    drive(pulse10(15));
    check_val("gap_valid_e16", rate_bus.rate_valid_o, 1);
    check_val("gap_rate", rate_bus.rate_o, 2);

    // Reset mid-window after three spikes.
    do_reset();
    for (int e = 0; e < 11; e++) drive(pulse5(e));
    rst_n = 1'b0;
    drive(-8'sd32);
    check_val("mid_rst_spike", spike_o, 0);
    check_val("mid_rst_rate", rate_bus.rate_o, 0);
    check_val("mid_rst_valid", rate_bus.rate_valid_o, 0);
    check_val("mid_rst_overrun", overrun_o, 0);
    check_val("mid_rst_isi", isi_o, 0);
    rst_n = 1'b1;
    drive(8'sd40);
    for (int e = 1; e < 15; e++) drive(-8'sd32);
    check_val("post_rst_valid_c15", rate_bus.rate_valid_o, 0);
    drive(-8'sd32);
    check_val("post_rst_valid_c16", rate_bus.rate_valid_o, 1);
    check_val("post_rst_rate", rate_bus.rate_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spike_train_decoder.md
SPIKE_TRAIN_DECODER -- requirements
Module: spike_train_decoder

Interface
REQ-001 Parameter WIN_LOG2, default 10: rate window length is 2**WIN_LOG2 enabled cycles.
REQ-002 Parameter ISI_W, default 16: inter-spike-interval counter width.
REQ-003 Parameter HYST, default 8'sd32: re-arm hysteresis below threshold, signed.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 ena  input  1  advance enable; when low all state holds and no events occur.
REQ-007 v_in  input  8  signed membrane voltage sample, one per enabled cycle (neuron uo_out format).
REQ-008 thresh  input  8  signed spike threshold, sampled every enabled cycle.
REQ-009 spike_o  output  1  one-cycle pulse on each detected spike.
REQ-010 rate_o  output  8  spike count of the last completed window.
REQ-011 rate_valid_o  output  1  rate_o holds an unconsumed result.
REQ-012 rate_ready_i  input  1  consumer accepts rate_o when high with rate_valid_o.
REQ-013 overrun_o  output  1  sticky: a window result was overwritten before acceptance.
REQ-014 isi_o  output  ISI_W  enabled cycles between the last two spikes.

Function
REQ-015 Detector FSM states ARMED and FIRED; reset state ARMED.
REQ-016 ARMED -> FIRED when ena and v_in > thresh (signed); spike_o high the following cycle for exactly one cycle.
REQ-017 FIRED -> ARMED when ena and v_in < thresh - HYST (computed 9-bit signed, no wrap); no spike on this transition.
REQ-018 v_in continuously above thresh yields exactly one spike.
REQ-019 Window counter increments each enabled cycle, wraps 2**WIN_LOG2-1 -> 0.
REQ-020 Spike counter increments per spike, saturates at 255.
REQ-021 On window wrap: rate_o <= spike count including a spike registered on the terminal cycle; spike counter <= 0; rate_valid_o <= 1.
REQ-022 Handshake: rate_valid_o clears the cycle after rate_valid_o & rate_ready_i; rate_o stable while valid and not accepted.
REQ-023 Wrap while rate_valid_o=1 and not accepted that cycle: rate_o overwritten, rate_valid_o stays 1, overrun_o <= 1.
REQ-024 Wrap coinciding with acceptance: new result loaded, rate_valid_o stays 1, no overrun.
REQ-025 ISI counter increments each enabled cycle, saturates at all-ones; on spike isi_o <= counter value, counter <= 1.
REQ-026 rate_ready_i is honoured regardless of ena.

Reset
REQ-027 On rst_n low at a clock edge: state ARMED, all counters 0, spike_o 0, rate_o 0, rate_valid_o 0, overrun_o 0, isi_o 0.
REQ-028 Reset mid-window discards the partial count; first post-reset window is a full 2**WIN_LOG2 cycles.

Configuration
REQ-029 Macro SPIKE_TRAIN_DECODER_ISI_EN defined: ISI counter and isi_o logic per REQ-025.
REQ-030 Macro undefined: no ISI registers; isi_o tied to 0; all other behaviour identical.

Structure
REQ-031 Package spike_pkg holds detector state enum, default THRESH (8'sd16) and HYST constants, rate width (8).
REQ-032 Sub-module spike_detector implements REQ-015..REQ-018 (FSM plus spike pulse); counters and handshake in top.

Verification
REQ-033 v_in held 8'sd40, thresh 16 -> single spike_o pulse one cycle after first sample; none thereafter.
REQ-034 v_in alternating 40 / -32 every 4 cycles, WIN_LOG2=4 -> rate_o=2 per window, rate_valid_o at cycle 16.
REQ-035 rate_ready_i low for two windows -> rate_o shows second result, overrun_o=1, rate_valid_o=1.
REQ-036 Spikes every 10 cycles, ISI_EN defined -> isi_o=10; undefined -> isi_o=0.
REQ-037 ena low for 50 cycles mid-window -> no counter/ISI advance; window closes 50 cycles late.
REQ-038 rst_n low mid-window with 3 spikes counted -> all outputs 0; next window result excludes them.
